// File: rtl/debounce_sync.sv
// ---------------------------------------------------------------------------
// debounce_sync
// Conditions one raw asynchronous input for synchronous use. A reset-capable
// flip-flop chain brings the input into the clock domain. A counter-qualified
// FSM then accepts a new level only after STABLE_CNT consecutive identical
// samples. The block emits the clean level plus one-clock rise/fall pulses.
//
// Ports
//   clock      : system clock, rising-edge active
//   reset_n    : asynchronous active-low reset
//   noisy_in   : raw asynchronous input (may bounce/glitch)
//   level_out  : debounced, synchronized level (registered)
//   rise_pulse : one-clock pulse on level_out 0->1 (registered)
//   fall_pulse : one-clock pulse on level_out 1->0 (registered)
// ---------------------------------------------------------------------------
module debounce_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CNT  = 50000,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter logic        RSTVAL      = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic noisy_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_e;

  localparam state_e                RST_STATE = RSTVAL ? STABLE_HI : STABLE_LO;
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(STABLE_CNT - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = '0;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sample;

  // Plain shift chain: no logic between stages.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], noisy_in};
  assign sample = sync_q[SYNC_STAGES-1];

  // Next-state logic; a WAIT state enters with count 1 because the sample
  // that triggered the exit from STABLE is the first of the new level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (sample) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      WAIT_HI: begin
        if (!sample) begin
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sample) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      WAIT_LO: begin
        if (sample) begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RST_STATE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State and output registers; reset abandons any pending transition.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= {SYNC_STAGES{RSTVAL}};
      state_q <= RST_STATE;
      cnt_q   <= CNT_ZERO;
      level_q <= RSTVAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_debounce_sync.sv
// ---------------------------------------------------------------------------
// tb_debounce_sync
// Directed bench for debounce_sync with SYNC_STAGES=2, STABLE_CNT=4.
// dut0 uses RSTVAL=0, dut1 uses RSTVAL=1. Inputs change and outputs are
// sampled 1 ns after each rising edge. With the input changed before edge n,
// the new level is expected after edge n+5 (the 6th tick).
// ---------------------------------------------------------------------------
module tb_debounce_sync;

  logic clock;
  logic rst0_n, rst1_n;
  logic noisy0, noisy1;
  logic level0, rise0, fall0;
  logic level1, rise1, fall1;

  int n_checks;
  int n_fail;
  int rise_seen0, fall_seen0, rise_seen1, fall_seen1;
  int both_high;

  debounce_sync #(
    .SYNC_STAGES(2), .STABLE_CNT(4), .CNT_WIDTH(16), .RSTVAL(1'b0)
  ) dut0 (
    .clock(clock), .reset_n(rst0_n), .noisy_in(noisy0),
    .level_out(level0), .rise_pulse(rise0), .fall_pulse(fall0)
  );

  debounce_sync #(
    .SYNC_STAGES(2), .STABLE_CNT(4), .CNT_WIDTH(16), .RSTVAL(1'b1)
  ) dut1 (
    .clock(clock), .reset_n(rst1_n), .noisy_in(noisy1),
    .level_out(level1), .rise_pulse(rise1), .fall_pulse(fall1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulses must never overlap on either instance.
  always @(negedge clock) begin
    if ((rise0 === 1'b1 && fall0 === 1'b1) || (rise1 === 1'b1 && fall1 === 1'b1))
      both_high = both_high + 1;
  end

  // Advance one edge and tally pulses seen.
  task automatic tick();
    @(posedge clock);
    #1;
    if (rise0 === 1'b1) rise_seen0 = rise_seen0 + 1;
    if (fall0 === 1'b1) fall_seen0 = fall_seen0 + 1;
    if (rise1 === 1'b1) rise_seen1 = rise_seen1 + 1;
    if (fall1 === 1'b1) fall_seen1 = fall_seen1 + 1;
  endtask

  task automatic test_reset();
    rst0_n = 1'b0;
    noisy0 = 1'b0;
    #1;
    n_checks++;
    if (level0 !== 1'b0 || rise0 !== 1'b0 || fall0 !== 1'b0) begin
      $display("FAIL reset_outputs: level=%b rise=%b fall=%b required 0/0/0", level0, rise0, fall0);
      n_fail++;
    end
    n_checks++;
    if (dut0.cnt_q !== 16'd0) begin
      $display("FAIL reset_counter: cnt=%0d required 0", dut0.cnt_q);
      n_fail++;
    end
    @(negedge clock);
    rst0_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (level0 !== 1'b0 || rise0 !== 1'b0 || fall0 !== 1'b0) begin
        $display("FAIL idle_after_reset: tick %0d level=%b rise=%b fall=%b required 0/0/0",
                 i, level0, rise0, fall0);
        n_fail++;
      end
    end
  endtask

  task automatic test_clean_rise();
    int r0, f0;
    r0 = rise_seen0;
    f0 = fall_seen0;
    noisy0 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++;
      if (level0 !== 1'b0 || rise0 !== 1'b0) begin
        $display("FAIL rise_early: tick %0d level=%b rise=%b required 0/0", k, level0, rise0);
        n_fail++;
      end
      if (k == 3) begin
        n_checks++;
        if (dut0.cnt_q !== 16'd1) begin
          $display("FAIL rise_count_start: cnt=%0d required 1", dut0.cnt_q);
          n_fail++;
        end
      end
    end
    tick();
    n_checks++;
    if (level0 !== 1'b1 || rise0 !== 1'b1) begin
      $display("FAIL rise_accept: level=%b rise=%b required 1/1", level0, rise0);
      n_fail++;
    end
    tick();
    n_checks++;
    if (level0 !== 1'b1 || rise0 !== 1'b0) begin
      $display("FAIL rise_pulse_end: level=%b rise=%b required 1/0", level0, rise0);
      n_fail++;
    end
    n_checks++;
    if (rise_seen0 - r0 != 1 || fall_seen0 != f0) begin
      $display("FAIL rise_pulse_count: rise=%0d fall=%0d required 1/0",
               rise_seen0 - r0, fall_seen0 - f0);
      n_fail++;
    end
  endtask

  task automatic test_fall();
    int r0, f0;
    r0 = rise_seen0;
    f0 = fall_seen0;
    noisy0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++;
      if (level0 !== 1'b1 || fall0 !== 1'b0) begin
        $display("FAIL fall_early: tick %0d level=%b fall=%b required 1/0", k, level0, fall0);
        n_fail++;
      end
    end
    tick();
    n_checks++;
    if (level0 !== 1'b0 || fall0 !== 1'b1) begin
      $display("FAIL fall_accept: level=%b fall=%b required 0/1", level0, fall0);
      n_fail++;
    end
    tick();
    n_checks++;
    if (level0 !== 1'b0 || fall0 !== 1'b0) begin
      $display("FAIL fall_pulse_end: level=%b fall=%b required 0/0", level0, fall0);
      n_fail++;
    end
    n_checks++;
    if (fall_seen0 - f0 != 1 || rise_seen0 != r0) begin
      $display("FAIL fall_pulse_count: fall=%0d rise=%0d required 1/0",
               fall_seen0 - f0, rise_seen0 - r0);
      n_fail++;
    end
  endtask

  task automatic test_bounce_reject();
    int r0, f0;
    logic [9:0] pattern;
    r0 = rise_seen0;
    f0 = fall_seen0;
    // high 3, low 2, high 3, then low (LSB first)
    pattern = 10'b00_1110_0111;
    for (int k = 0; k < 10; k++) begin
      noisy0 = pattern[k];
      tick();
      n_checks++;
      if (level0 !== 1'b0) begin
        $display("FAIL bounce_level: tick %0d level=%b required 0", k, level0);
        n_fail++;
      end
    end
    for (int k = 0; k < 4; k++) tick();
    n_checks++;
    if (level0 !== 1'b0 || rise_seen0 != r0 || fall_seen0 != f0) begin
      $display("FAIL bounce_no_pulse: level=%b rise=%0d fall=%0d required 0/0/0",
               level0, rise_seen0 - r0, fall_seen0 - f0);
      n_fail++;
    end
    n_checks++;
    if (dut0.cnt_q !== 16'd0) begin
      $display("FAIL bounce_counter: cnt=%0d required 0", dut0.cnt_q);
      n_fail++;
    end
  endtask

  task automatic test_bounce_settle();
    int r0;
    r0 = rise_seen0;
    noisy0 = 1'b1; tick();
    noisy0 = 1'b0; tick();
    noisy0 = 1'b1; tick();
    noisy0 = 1'b0; tick();
    noisy0 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++;
      if (level0 !== 1'b0) begin
        $display("FAIL settle_early: tick %0d level=%b required 0", k, level0);
        n_fail++;
      end
    end
    tick();
    n_checks++;
    if (level0 !== 1'b1 || rise0 !== 1'b1) begin
      $display("FAIL settle_accept: level=%b rise=%b required 1/1", level0, rise0);
      n_fail++;
    end
    for (int k = 0; k < 3; k++) tick();
    n_checks++;
    if (rise_seen0 - r0 != 1) begin
      $display("FAIL settle_pulse_count: rise=%0d required 1", rise_seen0 - r0);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_wait();
    int r0, f0;
    r0 = rise_seen0;
    f0 = fall_seen0;
    noisy0 = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    n_checks++;
    if (dut0.cnt_q !== 16'd2 || level0 !== 1'b0) begin
      $display("FAIL midwait_setup: cnt=%0d level=%b required 2/0", dut0.cnt_q, level0);
      n_fail++;
    end
    #2;
    rst0_n = 1'b0;
    noisy0 = 1'b0;
    #1;
    n_checks++;
    if (level0 !== 1'b0 || rise0 !== 1'b0 || fall0 !== 1'b0 || dut0.cnt_q !== 16'd0) begin
      $display("FAIL midwait_reset: level=%b rise=%b fall=%b cnt=%0d required 0/0/0/0",
               level0, rise0, fall0, dut0.cnt_q);
      n_fail++;
    end
    @(negedge clock);
    rst0_n = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    n_checks++;
    if (level0 !== 1'b0 || rise_seen0 != r0 || fall_seen0 != f0) begin
      $display("FAIL midwait_after: level=%b rise=%0d fall=%0d required 0/0/0",
               level0, rise_seen0 - r0, fall_seen0 - f0);
      n_fail++;
    end
  endtask

  task automatic test_rstval1();
    int r1, f1;
    n_checks++;
    if (level1 !== 1'b1 || rise1 !== 1'b0 || fall1 !== 1'b0) begin
      $display("FAIL rstval1_reset: level=%b rise=%b fall=%b required 1/0/0", level1, rise1, fall1);
      n_fail++;
    end
    r1 = rise_seen1;
    f1 = fall_seen1;
    @(negedge clock);
    rst1_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if (level1 !== 1'b1 || rise1 !== 1'b0 || fall1 !== 1'b0) begin
        $display("FAIL rstval1_idle: tick %0d level=%b rise=%b fall=%b required 1/0/0",
                 k, level1, rise1, fall1);
        n_fail++;
      end
    end
    noisy1 = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    n_checks++;
    if (level1 !== 1'b1) begin
      $display("FAIL rstval1_fall_early: level=%b required 1", level1);
      n_fail++;
    end
    tick();
    n_checks++;
    if (level1 !== 1'b0 || fall1 !== 1'b1 || rise_seen1 != r1 || fall_seen1 - f1 != 1) begin
      $display("FAIL rstval1_fall: level=%b fall=%b rise_n=%0d fall_n=%0d required 0/1/0/1",
               level1, fall1, rise_seen1 - r1, fall_seen1 - f1);
      n_fail++;
    end
  endtask

  task automatic test_pulse_exclusive();
    n_checks++;
    if (both_high != 0) begin
      $display("FAIL pulse_exclusive: overlapping cycles=%0d required 0", both_high);
      n_fail++;
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rise_seen0 = 0;
    fall_seen0 = 0;
    rise_seen1 = 0;
    fall_seen1 = 0;
    both_high  = 0;
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    noisy0 = 1'b0;
    noisy1 = 1'b1;
    #1;
    rst1_n = 1'b0;
    test_reset();
    test_clean_rise();
    test_fall();
    test_bounce_reject();
    test_bounce_settle();
    test_fall();
    test_reset_mid_wait();
    test_rstval1();
    test_pulse_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions one raw asynchronous input (push-button, switch, external strobe) for use by downstream synchronous logic.
- Front end is a chain of SYNC_STAGES resettable D flip-flop stages.
- Behind the chain, a counter-qualified state machine accepts a new level only after it has been stable for STABLE_CNT consecutive clocks.
- Outputs a clean level plus single-cycle rise and fall pulses, which feed counters, FSM triggers and shifters.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages in the synchronizer chain; legal range 2..4.
- STABLE_CNT, 50000, consecutive stable samples required to accept a new level; must be >= 2.
- CNT_WIDTH, 16, stability counter width; must satisfy 2**CNT_WIDTH > STABLE_CNT - 1.
- RSTVAL, 1'b0, reset value of every synchronizer stage and of level_out; selects the reset FSM state.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- noisy_in  input  1  raw asynchronous input; may bounce or glitch arbitrarily.
- level_out  output  1  debounced, synchronized level.
- rise_pulse  output  1  high for exactly one clock when level_out goes 0->1.
- fall_pulse  output  1  high for exactly one clock when level_out goes 1->0.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect without a clock edge):
  - all sync stages = RSTVAL; level_out = RSTVAL; rise_pulse = fall_pulse = 0; counter = 0.
  - state = STABLE_HI if RSTVAL = 1, else STABLE_LO.
- Reset release: synchronous operation resumes on the first rising edge with reset_n high.
- Synchronizer:
  - stage0 <= noisy_in; stage[i] <= stage[i-1].
  - sync_q = last stage.
  - No logic between stages.
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO. The sampled value is sync_q at the rising edge.
  - STABLE_LO: sync_q = 1 -> WAIT_HI, counter <= 1; else stay, counter held 0.
  - WAIT_HI, sync_q = 1, counter = STABLE_CNT-1 -> STABLE_HI, level_out <= 1, rise_pulse <= 1, counter <= 0.
  - WAIT_HI, sync_q = 1, counter < STABLE_CNT-1 -> counter <= counter+1.
  - WAIT_HI, sync_q = 0 -> STABLE_LO, counter <= 0. No output change, no pulse.
  - STABLE_HI and WAIT_LO: mirror image of the above with polarity inverted; fall_pulse in place of rise_pulse.
- Acceptance edge: level_out changes on the edge that samples the STABLE_CNT-th consecutive new-level value of sync_q.
- Latency: noisy_in changes before edge n and stays stable -> level_out changes at edge n + SYNC_STAGES + STABLE_CNT - 1.
  - Example: SYNC_STAGES=2, STABLE_CNT=4 -> edge n+5.
- Pulses:
  - Registered; asserted in the same cycle level_out takes its new value.
  - Deasserted on the following edge.
  - Never both high at once.
  - Exactly one pulse per level_out transition.
- Glitch rejection: a disturbance lasting fewer than STABLE_CNT sampled cycles produces no output change.
- Counter rules:
  - Never exceeds STABLE_CNT-1.
  - No wrap-around.
  - Cleared on every return to a STABLE state.
- level_out is a direct flop output; no combinational path from noisy_in to any output.
- Reset mid-WAIT: the pending transition is abandoned with no pulse. After release, the FSM restarts from the RSTVAL-selected state.

Test Plan (SYNC_STAGES=2, STABLE_CNT=4, RSTVAL=0 unless stated):
- Reset + idle: reset_n low, noisy_in=0 -> level_out=0, pulses 0, state STABLE_LO; remain so for 20 clocks after release.
- Clean rise: noisy_in 0->1 before edge n, held -> level_out=1 at edge n+5; rise_pulse=1 for exactly cycle n+5..n+6; fall_pulse stays 0.
- Bounce rejection: noisy_in high for 3 clocks, low for 2, high for 3, then low -> level_out stays 0, no pulses, counter back to 0.
- Bounce then settle: 1,0,1,0 pattern at one-clock intervals, then held 1 -> level_out rises 5 edges after the final 0->1 change; exactly one rise_pulse.
- Fall path: from level_out=1, noisy_in -> 0 held -> level_out=0 at +5 edges; one fall_pulse; rise_pulse stays 0.
- Reset mid-operation and RSTVAL=1:
  - Assert reset_n during WAIT_HI (counter=2) -> outputs return to reset values immediately, no pulse emitted.
  - Separate run with RSTVAL=1, noisy_in=1 -> level_out=1 from reset, no pulse after release.
